// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and a four-digit key history.
// Define KEYPAD_HEXMAP_EN to map row/column codes onto the printed keypad legend.
module keypad_scan #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col,
    input  logic        clr,
    output logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] digits
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_SCANS - 1);

    logic [3:0]          col_meta;
    logic [3:0]          col_sync;
    logic [SCAN_DIV-1:0] div;
    logic                tick;

    state_t     state, state_next;
    logic [1:0] ridx, ridx_next;
    logic [1:0] cidx, cidx_next;
    logic [3:0] cnt, cnt_next;
    logic       accept;
    logic       any_low;
    logic       key_high;
    logic [1:0] low_idx;
    logic [3:0] code;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
            div      <= '0;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
            div      <= div + 1'b1;
        end
    end

    assign tick     = &div;
    assign any_low  = ~&col_sync;
    assign key_high = col_sync[cidx];

    always_comb begin
        low_idx = 2'd0;
        if (!col_sync[0])      low_idx = 2'd0;
        else if (!col_sync[1]) low_idx = 2'd1;
        else if (!col_sync[2]) low_idx = 2'd2;
        else if (!col_sync[3]) low_idx = 2'd3;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SCAN;
            ridx  <= 2'd0;
            cidx  <= 2'd0;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            ridx  <= ridx_next;
            cidx  <= cidx_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        ridx_next  = ridx;
        cidx_next  = cidx;
        cnt_next   = cnt;
        accept     = 1'b0;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (any_low) begin
                        cidx_next  = low_idx;
                        cnt_next   = 4'd1;
                        state_next = DEBOUNCE;
                    end else begin
                        ridx_next = ridx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!key_high) begin
                        if (cnt == CNT_LAST) begin
                            accept     = 1'b1;
                            state_next = HELD;
                        end else begin
                            cnt_next = cnt + 4'd1;
                        end
                    end else begin
                        state_next = SCAN;
                        ridx_next  = ridx + 2'd1;
                    end
                end
                HELD: begin
                    if (key_high) begin
                        cnt_next   = 4'd1;
                        state_next = RELEASE;
                    end
                end
                RELEASE: begin
                    if (key_high) begin
                        if (cnt == CNT_LAST) begin
                            state_next = SCAN;
                            ridx_next  = ridx + 2'd1;
                        end else begin
                            cnt_next = cnt + 4'd1;
                        end
                    end else begin
                        state_next = HELD;
                    end
                end
            endcase
        end
    end

    always_comb begin
        row = ~(4'b0001 << ridx);
`ifdef KEYPAD_HEXMAP_EN
        unique case ({ridx, cidx})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
        endcase
`else
        code = {ridx, cidx};
`endif
    end

    // A clear that lands on an accept keeps only the new key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            digits    <= 16'd0;
        end else begin
            key_valid <= accept;
            if (accept) key_code <= code;
            if (clr)
                digits <= accept ? {12'h000, code} : 16'd0;
            else if (accept)
                digits <= {digits[11:0], code};
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a physical keypad model drives col from row,
// and a reference of the key legend and digit history predicts every accepted key.
module tb_keypad_scan;

    localparam int TICK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] digits;

    logic [15:0] pressed = 16'h0000;
    logic [15:0] model = 16'h0000;
    int          total = 0;
    int          bad = 0;
    int          pulses = 0;

    logic [3:0] legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scan #(.SCAN_DIV(2), .DEBOUNCE_SCANS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col       (col),
        .clr       (clr),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .digits    (digits)
    );

    always #5 clk = ~clk;

    // A pressed switch shorts its column to its row; rows are strobed low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        if (key_valid === 1'b1) pulses++;
    end

    function automatic logic [3:0] ref_code(input int r, input int c);
`ifdef KEYPAD_HEXMAP_EN
        return legend[r*4+c];
`else
        return 4'(r*4 + c);
`endif
    endfunction

    function automatic int pos_of(input logic [3:0] code);
        for (int p = 0; p < 16; p++)
            if (ref_code(p / 4, p % 4) == code) return p;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_row(input logic [3:0] target);
        int n = 0;
        while (row !== target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_row", {12'h000, row}, {12'h000, target});
    endtask

    task automatic wait_pulse(input int p0, input int r, input int c);
        int n = 0;
        while (pulses == p0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        model = {model[11:0], ref_code(r, c)};
        check("pulse_count", 16'(pulses - p0), 16'd1);
        check("key_code", {12'h000, key_code}, {12'h000, ref_code(r, c)});
        check("digits", digits, model);
    endtask

    task automatic release_all(input int p0);
        pressed = 16'h0000;
        repeat (12 * TICK) @(negedge clk);
        check("no_repeat", 16'(pulses - p0), 16'd1);
    endtask

    task automatic press_release(input int r, input int c, input int hold_ticks);
        int p0 = pulses;
        pressed[r*4+c] = 1'b1;
        wait_pulse(p0, r, c);
        repeat (hold_ticks * TICK) @(negedge clk);
        check("held_no_pulse", 16'(pulses - p0), 16'd1);
        release_all(p0);
    endtask

    initial begin
        int p0;
        int p;

        repeat (3) @(negedge clk);
        check("rst_row", {12'h000, row}, 16'h000E);
        check("rst_valid", {15'h0000, key_valid}, 16'h0000);
        check("rst_code", {12'h000, key_code}, 16'h0000);
        check("rst_digits", digits, 16'h0000);

        // Idle scan: the divider restarts at zero, so the row advances every fourth clk.
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("idle_row", {12'h000, row}, {12'h000, ~(4'b0001 << ((k / TICK) % 4))});
        end
        check("idle_no_pulse", 16'(pulses), 16'd0);

        // Long hold of row1/col2, then release.
        press_release(1, 2, 20);
        check("first_key_digits", digits, {12'h000, ref_code(1, 2)});

        // Row3/col1 bounces high on the second debounce tick.
        p0 = pulses;
        wait_row(4'b1011);
        wait_row(4'b0111);
        pressed[13] = 1'b1;
        repeat (5) @(negedge clk);
        pressed[13] = 1'b0;
        repeat (3) @(negedge clk);
        pressed[13] = 1'b1;
        check("bounce_no_pulse", 16'(pulses - p0), 16'd0);
        wait_pulse(p0, 3, 1);
        repeat (3 * TICK) @(negedge clk);
        release_all(p0);

        // Plain clear.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model = 16'h0000;
        check("clr_digits", digits, 16'h0000);

        // Keys 1..4, then clear coinciding with the accept of key 5.
        for (int d = 1; d <= 4; d++) begin
            p = pos_of(4'(d));
            press_release(p / 4, p % 4, 2);
        end
        check("four_keys", digits, 16'h1234);
        p0 = pulses;
        wait_row(4'b1110);
        wait_row(4'b1101);
        pressed[5] = 1'b1;
        repeat (11) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model = {12'h000, ref_code(1, 1)};
        check("clr_accept_valid", {15'h0000, key_valid}, 16'h0001);
        check("clr_accept_digits", digits, 16'h0005);
        release_all(p0);

        // Two columns on row2: lowest column wins, releasing the other adds nothing.
        p0 = pulses;
        pressed[8] = 1'b1;
        pressed[11] = 1'b1;
        wait_pulse(p0, 2, 0);
        repeat (3 * TICK) @(negedge clk);
        pressed[11] = 1'b0;
        repeat (10 * TICK) @(negedge clk);
        check("multi_partial_release", 16'(pulses - p0), 16'd1);
        release_all(p0);

        // Random keys with random hold times.
        for (int i = 0; i < 8; i++)
            press_release(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 6)));
        check("random_digits", digits, model);

        // Reset in the middle of a debounce drops the key.
        p0 = pulses;
        wait_row(4'b1110);
        wait_row(4'b1101);
        pressed[6] = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_row", {12'h000, row}, 16'h000E);
        check("mid_rst_digits", digits, 16'h0000);
        check("mid_rst_valid", {15'h0000, key_valid}, 16'h0000);
        pressed = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model = 16'h0000;
        repeat (20 * TICK) @(negedge clk);
        check("mid_rst_no_pulse", 16'(pulses - p0), 16'd0);

        press_release(0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16, tick-divider width in bits (legal range 2..26).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, number of consecutive ticks needed to accept a press or a release (legal range 2..15).
REQ-003 SHALL have port clk, input, 1, the only clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port col, input, 4, keypad columns, asynchronous, active-low (external pull-ups).
REQ-006 SHALL have port clr, input, 1, synchronous clear of digits.
REQ-007 SHALL have port row, output, 4, one-hot active-low row strobe.
REQ-008 SHALL have port key_code, output, 4, code of the last accepted key.
REQ-009 SHALL have port key_valid, output, 1, one-clk pulse per accepted key.
REQ-010 SHALL have port digits, output, 16, last four keys as nibbles, newest in [3:0]; feeds the 4-digit display numA bus directly.

Function
REQ-011 SHALL pass col through a 2-flop synchronizer; all decisions use the synchronized value only.
REQ-012 SHALL run a free SCAN_DIV-bit counter; tick is high for one clk when the counter equals all-ones, so ticks occur every 2^SCAN_DIV clk.
REQ-013 SHALL drive row = ~(1<<ridx) at all times; ridx changes only on tick.
REQ-014 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE; all transitions occur only on tick.
REQ-015 SCAN: on tick, if no synchronized col bit is low, ridx <= ridx+1 (3 wraps to 0); otherwise latch ridx and lowest-index low column cidx, set cnt=1, go to DEBOUNCE, hold ridx.
REQ-016 DEBOUNCE: on tick, if col[cidx] is low, cnt++; when cnt reaches DEBOUNCE_SCANS, accept and go to HELD; if col[cidx] is high, go to SCAN with ridx <= ridx+1.
REQ-017 Accept: on the clk after the accepting tick, key_valid=1 for exactly one clk, key_code = mapped code, and digits <= {digits[11:0], code}.
REQ-018 HELD: on tick, if col[cidx] is high, set cnt=1 and go to RELEASE; otherwise stay. There is no auto-repeat.
REQ-019 RELEASE: on tick, if col[cidx] is high, cnt++; when cnt reaches DEBOUNCE_SCANS, go to SCAN with ridx <= ridx+1; if col[cidx] is low, return to HELD.
REQ-020 Other columns pressed while the FSM is outside SCAN SHALL be ignored; a multi-key press in SCAN selects the lowest column index.
REQ-021 clr SHALL zero digits on the next clk; if clr coincides with an accept, the result is digits = {12'h000, code}.
REQ-022 The raw code SHALL be ridx*4+cidx.

Reset
REQ-023 With rst_n low at a clk edge: state=SCAN, ridx=0, row=4'b1110, cnt=0, divider=0, synchronizer=4'hF, key_code=0, key_valid=0, digits=0.
REQ-024 Reset SHALL take priority over tick, clr and accept; reset in the middle of a debounce discards the pending key with no key_valid pulse.

Configuration
REQ-025 Macro KEYPAD_HEXMAP_EN defined: the code SHALL be mapped to the standard 4x4 keypad legend, row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 E(*),0,F(#),D.
REQ-026 Macro KEYPAD_HEXMAP_EN undefined: the code SHALL equal the raw code of REQ-022.

Verification (SCAN_DIV=2, DEBOUNCE_SCANS=3)
REQ-027 Idle after reset, col=4'hF -> row cycles 1110,1101,1011,0111,1110 and changes every 4 clk; key_valid stays 0.
REQ-028 Hold key row1/col2 for 20 ticks, then release -> exactly one key_valid pulse, key_code=4'h6 (hexmap) or 4'h6 (raw), digits=16'h0006; no second pulse.
REQ-029 Press row3/col1, bouncing high on the 2nd tick, then stable -> no pulse at the bounce; one pulse after 3 stable ticks; key_code=4'h0 (hexmap) or 4'hD (raw).
REQ-030 Enter keys 1,2,3,4 with clean releases, then assert clr coincident with a 5th key 5 -> digits=16'h1234 after the fourth key, then 16'h0005.
REQ-031 Pull rst_n low while in DEBOUNCE -> no key_valid; on the next clk row=4'b1110 and digits=0.
REQ-032 Press col0 and col3 on row2 together -> key_code=4'h7 (hexmap) or 4'h8 (raw); releasing col3 only causes no new pulse.
